// File: rtl/ahb_arbiter_2m_pkg.sv
// Shared types and default sizing for the two-master AHB-style arbiter.
package ahb_arbiter_2m_pkg;

  localparam int ADDR_W_DEF  = 11;
  localparam int DATA_W_DEF  = 8;
  localparam int TMO_CYC_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

endpackage

// File: rtl/ahb_arbiter_2m_rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins; a tie goes to the
// master that was not served last (last = 1 means m1 was served last).
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] winner
);

  always_comb begin
    winner = req;
    if (req == 2'b11) begin
      winner = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/ahb_arbiter_2m.sv
// Two-master arbiter onto one shared bus with two slaves split on the address MSB.
// Transfers run IDLE -> ADDR -> DATA; done/rdata/err are registered out of DATA.
module ahb_arbiter_2m
  import ahb_arbiter_2m_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic              hclk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_grant,
  output logic              m1_grant,
  output logic              m0_done,
  output logic              m1_done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [ADDR_W-1:0] haddr,
  output logic              hwrite,
  output logic [DATA_W-1:0] hwdata,
  output logic              hsel0,
  output logic              hsel1,
  input  logic [DATA_W-1:0] hrdata0,
  input  logic [DATA_W-1:0] hrdata1,
  input  logic              hready
);

  localparam int CNT_W = $clog2(TMO_CYC + 1);

  state_t            state, state_next;
  logic              last;
  logic              owner;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic [1:0]        win;
  logic              start, finish, tmo;
  logic [1:0]        done_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              bus_on;

  rr_arb2 u_rr (
    .req    ({m1_req, m0_req}),
    .last   (last),
    .winner (win)
  );

  // Arbitration is held off while a done pulse is out, since the finishing
  // master still has its req high in that cycle.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    finish     = 1'b0;
    tmo        = 1'b0;
    case (state)
      IDLE: begin
        if ((|win) && !(|done_q)) begin
          start      = 1'b1;
          state_next = ADDR;
        end
      end
      ADDR: state_next = DATA;
      DATA: begin
        if (hready) begin
          finish     = 1'b1;
          state_next = IDLE;
        end else if (wait_cnt == CNT_W'(TMO_CYC - 1)) begin
          finish     = 1'b1;
          tmo        = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge hclk) begin
    if (reset) begin
      last     <= 1'b1;
      owner    <= 1'b0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      wait_cnt <= '0;
      done_q   <= 2'b00;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      done_q  <= 2'b00;
      rdata_q <= '0;
      err_q   <= 1'b0;
      if (start) begin
        owner   <= win[1];
        addr_q  <= win[1] ? m1_addr : m0_addr;
        write_q <= win[1] ? m1_write : m0_write;
        wdata_q <= win[1] ? m1_wdata : m0_wdata;
      end
      if (state == ADDR) begin
        wait_cnt <= '0;
      end else if (state == DATA && !hready) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (finish) begin
        done_q <= owner ? 2'b10 : 2'b01;
        err_q  <= tmo;
        last   <= owner;
        if (!tmo && !write_q) begin
          rdata_q <= addr_q[ADDR_W-1] ? hrdata1 : hrdata0;
        end
      end
    end
  end

  assign bus_on   = (state != IDLE);
  assign m0_grant = bus_on & ~owner;
  assign m1_grant = bus_on & owner;
  assign haddr    = bus_on ? addr_q : '0;
  assign hwrite   = bus_on & write_q;
  assign hwdata   = bus_on ? wdata_q : '0;
  assign hsel0    = bus_on & ~addr_q[ADDR_W-1];
  assign hsel1    = bus_on & addr_q[ADDR_W-1];
  assign m0_done  = done_q[0];
  assign m1_done  = done_q[1];
  assign rdata    = rdata_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ahb_arbiter_2m.sv
// Directed bench for ahb_arbiter_2m: single read, ties, upper-bank write,
// wait states, timeout and mid-transfer reset, with hand-computed expectations.
module tb_ahb_arbiter_2m;

  logic        hclk;
  logic        reset;
  logic        m0_req, m1_req;
  logic [10:0] m0_addr, m1_addr;
  logic        m0_write, m1_write;
  logic [7:0]  m0_wdata, m1_wdata;
  logic        m0_grant, m1_grant, m0_done, m1_done;
  logic [7:0]  rdata;
  logic        err;
  logic [10:0] haddr;
  logic        hwrite;
  logic [7:0]  hwdata;
  logic        hsel0, hsel1;
  logic [7:0]  hrdata0, hrdata1;
  logic        hready;

  int n_vec = 0;
  int n_err = 0;

  ahb_arbiter_2m dut (
    .hclk     (hclk),
    .reset    (reset),
    .m0_req   (m0_req),
    .m0_addr  (m0_addr),
    .m0_write (m0_write),
    .m0_wdata (m0_wdata),
    .m1_req   (m1_req),
    .m1_addr  (m1_addr),
    .m1_write (m1_write),
    .m1_wdata (m1_wdata),
    .m0_grant (m0_grant),
    .m1_grant (m1_grant),
    .m0_done  (m0_done),
    .m1_done  (m1_done),
    .rdata    (rdata),
    .err      (err),
    .haddr    (haddr),
    .hwrite   (hwrite),
    .hwdata   (hwdata),
    .hsel0    (hsel0),
    .hsel1    (hsel1),
    .hrdata0  (hrdata0),
    .hrdata1  (hrdata1),
    .hready   (hready)
  );

  // clock / reset
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".m0_grant"}, 32'(m0_grant), 0);
    check({tag, ".m1_grant"}, 32'(m1_grant), 0);
    check({tag, ".haddr"},    32'(haddr),    0);
    check({tag, ".hwrite"},   32'(hwrite),   0);
    check({tag, ".hwdata"},   32'(hwdata),   0);
    check({tag, ".hsel0"},    32'(hsel0),    0);
    check({tag, ".hsel1"},    32'(hsel1),    0);
  endtask

  task automatic clear_inputs();
    m0_req = 0; m0_addr = '0; m0_write = 0; m0_wdata = '0;
    m1_req = 0; m1_addr = '0; m1_write = 0; m1_wdata = '0;
    hrdata0 = '0; hrdata1 = '0; hready = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    do_reset();

    // reset state
    check_idle("rst");
    check("rst.m0_done", 32'(m0_done), 0);
    check("rst.m1_done", 32'(m1_done), 0);
    check("rst.rdata",   32'(rdata),   0);
    check("rst.err",     32'(err),     0);

    // single read from lower bank, minimum latency
    m0_req = 1; m0_addr = 11'h005; m0_write = 0;
    hrdata0 = 8'hA5; hrdata1 = 8'h11; hready = 1;
    tick();
    check("rd.a.m0_grant", 32'(m0_grant), 1);
    check("rd.a.m1_grant", 32'(m1_grant), 0);
    check("rd.a.haddr",    32'(haddr),    'h005);
    check("rd.a.hsel0",    32'(hsel0),    1);
    check("rd.a.hsel1",    32'(hsel1),    0);
    check("rd.a.hwrite",   32'(hwrite),   0);
    check("rd.a.m0_done",  32'(m0_done),  0);
    tick();
    check("rd.d.m0_grant", 32'(m0_grant), 1);
    check("rd.d.haddr",    32'(haddr),    'h005);
    check("rd.d.m0_done",  32'(m0_done),  0);
    tick();
    check("rd.m0_done", 32'(m0_done), 1);
    check("rd.m1_done", 32'(m1_done), 0);
    check("rd.rdata",   32'(rdata),   'hA5);
    check("rd.err",     32'(err),     0);
    check_idle("rd.done");
    m0_req = 0;
    tick();
    check("rd.post.m0_done", 32'(m0_done), 0);

    // ties from reset: m0, then m1 while m0 re-requests, then m0 again
    do_reset();
    m0_req = 1; m0_addr = 11'h010;
    m1_req = 1; m1_addr = 11'h020;
    hrdata0 = 8'h33; hready = 1;
    tick();
    check("tie1.m0_grant", 32'(m0_grant), 1);
    check("tie1.m1_grant", 32'(m1_grant), 0);
    check("tie1.haddr",    32'(haddr),    'h010);
    tick();
    tick();
    check("tie1.m0_done", 32'(m0_done), 1);
    check("tie1.m1_done", 32'(m1_done), 0);
    check("tie1.rdata",   32'(rdata),   'h33);
    m0_addr = 11'h030;
    tick();
    check("tie.gap.m0_grant", 32'(m0_grant), 0);
    check("tie.gap.m1_grant", 32'(m1_grant), 0);
    tick();
    check("tie2.m1_grant", 32'(m1_grant), 1);
    check("tie2.m0_grant", 32'(m0_grant), 0);
    check("tie2.haddr",    32'(haddr),    'h020);
    tick();
    tick();
    check("tie2.m1_done", 32'(m1_done), 1);
    check("tie2.m0_done", 32'(m0_done), 0);
    m1_req = 0;
    tick();
    check("tie.gap2.m0_grant", 32'(m0_grant), 0);
    tick();
    check("tie3.m0_grant", 32'(m0_grant), 1);
    check("tie3.haddr",    32'(haddr),    'h030);
    tick();
    tick();
    check("tie3.m0_done", 32'(m0_done), 1);
    m0_req = 0;
    tick();

    // upper-bank write from m1
    m1_req = 1; m1_addr = 11'h400; m1_write = 1; m1_wdata = 8'h3C;
    hrdata1 = 8'hFF; hready = 1;
    tick();
    check("wr.a.m1_grant", 32'(m1_grant), 1);
    check("wr.a.haddr",    32'(haddr),    'h400);
    check("wr.a.hsel1",    32'(hsel1),    1);
    check("wr.a.hsel0",    32'(hsel0),    0);
    check("wr.a.hwrite",   32'(hwrite),   1);
    check("wr.a.hwdata",   32'(hwdata),   'h3C);
    tick();
    check("wr.d.hsel1",  32'(hsel1),  1);
    check("wr.d.hwrite", 32'(hwrite), 1);
    check("wr.d.hwdata", 32'(hwdata), 'h3C);
    tick();
    check("wr.m1_done", 32'(m1_done), 1);
    check("wr.rdata",   32'(rdata),   0);
    check("wr.err",     32'(err),     0);
    m1_req = 0; m1_write = 0; m1_wdata = '0;
    tick();

    // five wait states
    m0_req = 1; m0_addr = 11'h123; hrdata0 = 8'h5A; hready = 0;
    tick();
    tick();
    check("ws.d.haddr", 32'(haddr), 'h123);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("ws.w%0d.m0_done", i),  32'(m0_done),  0);
      check($sformatf("ws.w%0d.m0_grant", i), 32'(m0_grant), 1);
      check($sformatf("ws.w%0d.haddr", i),    32'(haddr),    'h123);
      check($sformatf("ws.w%0d.hsel0", i),    32'(hsel0),    1);
    end
    hready = 1;
    tick();
    check("ws.m0_done", 32'(m0_done), 1);
    check("ws.rdata",   32'(rdata),   'h5A);
    check("ws.err",     32'(err),     0);
    m0_req = 0;
    tick();

    // timeout: hready never rises
    m1_req = 1; m1_addr = 11'h444; hrdata1 = 8'h77; hready = 0;
    tick();
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      check($sformatf("tmo.w%0d.m1_done", i),  32'(m1_done),  0);
      check($sformatf("tmo.w%0d.m1_grant", i), 32'(m1_grant), 1);
    end
    tick();
    check("tmo.m1_done", 32'(m1_done), 1);
    check("tmo.err",     32'(err),     1);
    check("tmo.rdata",   32'(rdata),   0);
    check_idle("tmo.done");
    m1_req = 0;
    tick();
    check("tmo.post.m1_done", 32'(m1_done), 0);
    check("tmo.post.err",     32'(err),     0);

    // m0 transfer leaves the pointer at m0, then reset hits m1's DATA phase
    m0_req = 1; m0_addr = 11'h001; hrdata0 = 8'h01; hready = 1;
    tick();
    tick();
    tick();
    check("pre.m0_done", 32'(m0_done), 1);
    m0_req = 0;
    tick();
    m1_req = 1; m1_addr = 11'h401; hrdata1 = 8'h99; hready = 0;
    tick();
    tick();
    check("mrst.d.m1_grant", 32'(m1_grant), 1);
    reset = 1; hready = 1;
    tick();
    check_idle("mrst");
    check("mrst.m1_done", 32'(m1_done), 0);
    check("mrst.m0_done", 32'(m0_done), 0);
    check("mrst.rdata",   32'(rdata),   0);
    check("mrst.err",     32'(err),     0);
    reset = 0; m1_req = 0; hready = 0;
    tick();
    check("mrst.post.m1_done", 32'(m1_done), 0);
    m0_req = 1; m0_addr = 11'h002;
    m1_req = 1; m1_addr = 11'h402;
    tick();
    check("mrst.tie.m0_grant", 32'(m0_grant), 1);
    check("mrst.tie.m1_grant", 32'(m1_grant), 0);
    clear_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter_2m.md
AHB_ARBITER_2M -- requirements
Module: ahb_arbiter_2m

Interface
REQ-001 Parameter ADDR_W, default 11, address width of each master and of the shared bus.
REQ-002 Parameter DATA_W, default 8, data width of each master and of the shared bus.
REQ-003 Parameter TMO_CYC, default 16, number of hready-low cycles in DATA before a timeout is declared.
REQ-004 hclk  in  1  single clock; all logic is rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 m0_req / m1_req  in  1  master request; held high until the matching done pulse.
REQ-007 m0_addr / m1_addr  in  ADDR_W  master address; stable while req is high.
REQ-008 m0_write / m1_write  in  1  1 = write, 0 = read.
REQ-009 m0_wdata / m1_wdata  in  DATA_W  master write data.
REQ-010 m0_grant / m1_grant  out  1  master currently owns the bus.
REQ-011 m0_done / m1_done  out  1  one-cycle transfer-complete pulse.
REQ-012 rdata  out  DATA_W  read data, valid in the done cycle.
REQ-013 err  out  1  timeout flag, valid in the done cycle.
REQ-014 haddr  out  ADDR_W  shared bus address.
REQ-015 hwrite  out  1  shared bus write strobe.
REQ-016 hwdata  out  DATA_W  shared bus write data.
REQ-017 hsel0 / hsel1  out  1  slave selects for memos0 and memos1.
REQ-018 hrdata0 / hrdata1  in  DATA_W  slave read data.
REQ-019 hready  in  1  slave ready; sampled only in DATA.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, ADDR and DATA.
REQ-021 In IDLE with any req high, the block SHALL grant one master, latch its addr/write/wdata and move to ADDR; with no req it SHALL stay in IDLE.
REQ-022 Arbitration SHALL be round-robin: if both masters request, the one not served last wins; if only one requests, it wins regardless of the pointer.
REQ-023 grant SHALL assert in ADDR and DATA only, one-hot, for the owning master.
REQ-024 In ADDR, haddr/hwrite/hwdata SHALL carry the latched values, hsel0 SHALL equal ~haddr[ADDR_W-1] and hsel1 SHALL equal haddr[ADDR_W-1]; the FSM SHALL go to DATA after exactly one cycle.
REQ-025 Bus outputs and hsel SHALL hold throughout DATA and SHALL be zero in IDLE.
REQ-026 In DATA with hready=1, the block SHALL pulse the owner's done for one cycle, drive rdata from the selected slave's hrdata (0 on writes) and err=0, update the round-robin pointer to the owner, and return to IDLE.
REQ-027 In DATA, a wait counter SHALL count hready-low cycles; when it reaches TMO_CYC, the block SHALL complete as in REQ-026 but with err=1 and rdata=0.
REQ-028 The wait counter SHALL clear on entry to DATA and SHALL be $clog2(TMO_CYC+1) bits wide, with no wrap.
REQ-029 Minimum latency SHALL be 3 cycles from a req sampled in IDLE to done, with the done pulse in the cycle after the hready=1 sample.
REQ-030 A req deasserted mid-transfer SHALL NOT abort the transfer.
REQ-031 A new grant SHALL NOT be issued in the done cycle; the next arbitration SHALL occur in IDLE, leaving at least one idle bus cycle between transfers.

Reset
REQ-032 Reset SHALL force the FSM to IDLE, the round-robin pointer to "m1 last" (m0 wins first tie), and the counter to 0.
REQ-033 Reset SHALL force every output to 0.
REQ-034 Reset asserted mid-transfer SHALL drop all outputs to 0 in the next cycle, with no done pulse.

Structure
REQ-035 A shared package SHALL hold the state enum (IDLE, ADDR, DATA) and the default ADDR_W, DATA_W and TMO_CYC constants.
REQ-036 The round-robin decision SHALL be a sub-module rr_arb2 (inputs req[1:0] and last; output one-hot winner); all other logic SHALL be flat.

Verification
REQ-037 Single read: m0 reads addr 0x005, hrdata0=0xA5, hready=1 -> m0_done 3 cycles after req, rdata=0xA5, hsel0=1, err=0.
REQ-038 Tie: m0 and m1 request together from reset -> m0 served first, then m1; a second tie -> m1 served first.
REQ-039 Upper-bank write: m1 writes 0x3C to addr 0x400 -> hsel1=1, hwrite=1, hwdata=0x3C during ADDR/DATA; m1_done pulses with rdata=0.
REQ-040 Wait states: hready held low 5 cycles in DATA -> done 5 cycles later than nominal, bus outputs stable throughout, err=0.
REQ-041 Timeout: hready held low -> done after 16 DATA wait cycles, err=1, rdata=0, FSM back in IDLE.
REQ-042 Mid-transfer reset: reset pulsed in DATA -> all outputs 0 next cycle, no done; the next tie is won by m0.
